vc_pkt_scheduler: RTL
=====================

// Module: vc_pkt_scheduler
// PURPOSE
//  Wormhole-aware scheduler for the VC output mux of the input datapath.
//  Picks which VC buffer drives the shared output flit port each cycle.
//  Locks a VC from head-flit acceptance until its tail flit is accepted.
//  Policy: fixed priority or round-robin, with a starvation override.
// PARAMETERS
//  N_VIRT_CHN    2   number of virtual channels (>=1)
//  H_PRIORITY    0   fixed mode only: 1 = highest index wins, 0 = lowest
//  RR_EN         0   1 = round-robin among head-eligible VCs (ignores H_PRIORITY)
//  STARVE_LIMIT  16  waiting cycles before a VC is forced to win; 0 disables
// PORTS
//  clk           in   1       clock
//  arst          in   1       reset, synchronous, active-high
//  vc_valid_i    in   N       VC buffer n has a flit at its head
//  vc_head_i     in   N       head flit of VC n is a HEAD flit
//  vc_tail_i     in   N       head flit of VC n ends its packet (head+tail = 1-flit pkt)
//  vc_ready_o    out  N       pop for VC n; = gnt_o[n] & fout_ready_i
//  gnt_o         out  N       one-hot VC select for the output mux; zero when no grant
//  gnt_vc_o      out  VCW     index of the granted VC; VCW = $clog2(N>1?N:2)
//  fout_valid_o  out  1       output flit valid; = |(gnt_o & vc_valid_i)
//  fout_ready_i  in   1       downstream accepts the flit
//  locked_o      out  1       FSM is in LOCKED
//  err_o         out  1       sticky protocol-error flag
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: FSM=IDLE, lock_vc=0, rr_ptr=0, starvation counters=0, err_o=0.
//   All outputs are combinationally 0 while arst=1.
//  xfer = fout_valid_o & fout_ready_i. Grant is zero-latency (comb); state updates on the xfer edge.
//  IDLE:
//   - Eligible VC: vc_valid_i & vc_head_i.
//   - Winner order:
//     1. Any VC with counter == STARVE_LIMIT (lowest index among them).
//     2. Else RR_EN: first eligible after rr_ptr, wrapping.
//     3. Else fixed priority per H_PRIORITY.
//   - No eligible VC: gnt_o=0 and fout_valid_o=0.
//   - xfer with tail=0: go to LOCKED, lock_vc = winner.
//   - xfer with tail=1: stay IDLE.
//   - On any head xfer: rr_ptr = winner.
//  LOCKED:
//   - gnt_o = onehot(lock_vc) regardless of vc_valid_i; bubbles allowed (fout_valid_o=0).
//   - Other VCs are never granted.
//   - xfer with vc_tail_i[lock_vc]=1: go to IDLE. The next head may win in the following cycle.
//  Starvation counter per VC (width $clog2(STARVE_LIMIT+1)):
//   - Increments when VC is valid & head and not granted; saturates at STARVE_LIMIT.
//   - Clears on that VC's head xfer.
//  err_o sets (held until reset) when:
//   - IDLE sees vc_valid_i[n] & ~vc_head_i[n] for any n; that VC is ignored.
//   - LOCKED sees vc_head_i[lock_vc] & vc_valid_i[lock_vc]; that flit is still forwarded.
//  Boundary conditions:
//   - N_VIRT_CHN=1: grant is always VC0; RR and starvation logic are no-ops.
//   - fout_ready_i low holds gnt_o stable: the IDLE winner cannot change while its flit is
//     stalled, because the arbitration result is registered once fout_valid_o is high and
//     xfer=0 (hold register).
//   - Reset asserted mid-packet: lock dropped. Upstream must flush; no recovery of partial packets.
// STRUCTURE
//  ravenoc_pkg: N_VIRT_CHN, H_PRIORITY, STARVE_LIMIT, typedef vc_id_t [VCW-1:0],
//   typedef enum {SCH_IDLE, SCH_LOCKED} sched_st_t.
//  Sub-module rr_arbiter #(N): mask/unmask round-robin pick (req, ptr -> one-hot gnt).
//  Top holds the FSM, lock_vc, hold register, starvation counters and err logic.
// TESTING
//  1. N=2, RR_EN=0, H_PRIORITY=0: VC0 and VC1 present heads together
//     -> VC0 wins; VC1 waits; VC1 wins after VC0's tail.
//  2. 4-flit packet on VC1; VC0 head arrives at flit 2; fout_ready_i toggled
//     -> gnt stays on VC1 through the tail; VC0 granted the cycle after the tail xfer.
//  3. RR_EN=1, N=4, all VCs stream 1-flit packets -> grant order 1,2,3,0,1...
//  4. STARVE_LIMIT=3, H_PRIORITY=1, VC1 saturated, VC0 waiting
//     -> VC0 wins on its 4th waiting cycle; its counter clears.
//  5. Body flit on an idle VC -> ignored and err_o=1;
//     head on the locked VC -> forwarded and err_o stays 1 until arst.
//  6. arst pulsed during a locked packet
//     -> next cycle gnt_o=0 and locked_o=0; a fresh head is granted normally.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared defaults, types and helpers for the VC packet scheduler
package ravenoc_pkg;

  localparam int N_VIRT_CHN   = 2;
  localparam int H_PRIORITY   = 0;
  localparam int RR_EN        = 0;
  localparam int STARVE_LIMIT = 16;

  function automatic int vcw_of(input int n);
    return $clog2(n > 1 ? n : 2);
  endfunction

  localparam int VCW = vcw_of(N_VIRT_CHN);

  typedef logic [VCW-1:0] vc_id_t;

  typedef enum logic {
    SCH_IDLE   = 1'b0,
    SCH_LOCKED = 1'b1
  } sched_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: first request strictly after ptr_i, wrapping
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_src;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i > int'(ptr_i));
    end
  end

  // Prefer requests above the pointer; fall back to the full set to wrap around.
  assign w_masked = req_i & w_mask;
  assign w_src    = (|w_masked) ? w_masked : req_i;
  assign gnt_o    = w_src & (~w_src + N'(1));

endmodule

// File: rtl/vc_pkt_scheduler.sv
// rtl/vc_pkt_scheduler.sv - wormhole-aware VC output scheduler with lock, hold and starvation override
module vc_pkt_scheduler #(
  parameter int N_VIRT_CHN   = ravenoc_pkg::N_VIRT_CHN,
  parameter int H_PRIORITY   = ravenoc_pkg::H_PRIORITY,
  parameter int RR_EN        = ravenoc_pkg::RR_EN,
  parameter int STARVE_LIMIT = ravenoc_pkg::STARVE_LIMIT,
  localparam int VCW         = ravenoc_pkg::vcw_of(N_VIRT_CHN)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [N_VIRT_CHN-1:0] vc_valid_i,
  input  logic [N_VIRT_CHN-1:0] vc_head_i,
  input  logic [N_VIRT_CHN-1:0] vc_tail_i,
  output logic [N_VIRT_CHN-1:0] vc_ready_o,
  output logic [N_VIRT_CHN-1:0] gnt_o,
  output logic [VCW-1:0]        gnt_vc_o,
  output logic                  fout_valid_o,
  input  logic                  fout_ready_i,
  output logic                  locked_o,
  output logic                  err_o
);

  import ravenoc_pkg::*;

  localparam int N          = N_VIRT_CHN;
  localparam int CW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit USE_STARVE = (STARVE_LIMIT > 0) && (N > 1);
  localparam bit USE_RR     = (RR_EN != 0) && (N > 1);

  sched_st_t      r_state, w_next_state;
  logic [VCW-1:0] r_lock_vc, r_rr_ptr, r_hold_idx;
  logic           r_hold_vld, r_err;
  logic [CW-1:0]  r_cnt [N];

  logic [N-1:0]   w_elig, w_sat, w_rr_gnt, w_gnt;
  logic [VCW-1:0] w_win_idx, w_gnt_idx;
  logic           w_win_found, w_hold_live, w_idle, w_fout_valid, w_xfer;

  assign w_elig      = vc_valid_i & vc_head_i;
  assign w_idle      = (r_state == SCH_IDLE);
  assign w_hold_live = r_hold_vld & w_elig[r_hold_idx];

  rr_arbiter #(.N(N), .PW(VCW)) u_rr (
    .req_i (w_elig),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_rr_gnt)
  );

  // A stalled winner keeps the port until it moves, so a counter saturating meanwhile cannot preempt it.
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_sat       = '0;
    for (int i = 0; i < N; i++) begin
      w_sat[i] = USE_STARVE && w_elig[i] && (r_cnt[i] == CW'(STARVE_LIMIT));
    end
    if (w_hold_live) begin
      w_win_idx   = r_hold_idx;
      w_win_found = 1'b1;
    end else if (|w_sat) begin
      for (int i = N - 1; i >= 0; i--) if (w_sat[i]) w_win_idx = VCW'(i);
      w_win_found = 1'b1;
    end else if (USE_RR) begin
      for (int i = 0; i < N; i++) if (w_rr_gnt[i]) w_win_idx = VCW'(i);
      w_win_found = |w_rr_gnt;
    end else if (H_PRIORITY != 0) begin
      for (int i = 0; i < N; i++) if (w_elig[i]) w_win_idx = VCW'(i);
      w_win_found = |w_elig;
    end else begin
      for (int i = N - 1; i >= 0; i--) if (w_elig[i]) w_win_idx = VCW'(i);
      w_win_found = |w_elig;
    end
  end

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    if (w_idle) begin
      if (w_win_found) begin
        w_gnt[w_win_idx] = 1'b1;
        w_gnt_idx        = w_win_idx;
      end
    end else begin
      w_gnt[r_lock_vc] = 1'b1;
      w_gnt_idx        = r_lock_vc;
    end
  end

  assign w_fout_valid = |(w_gnt & vc_valid_i);
  assign w_xfer       = w_fout_valid & fout_ready_i;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SCH_IDLE:   if (w_xfer && !vc_tail_i[w_win_idx]) w_next_state = SCH_LOCKED;
      SCH_LOCKED: if (w_xfer && vc_tail_i[r_lock_vc])  w_next_state = SCH_IDLE;
      default:    w_next_state = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state    <= SCH_IDLE;
      r_lock_vc  <= '0;
      r_rr_ptr   <= '0;
      r_hold_vld <= 1'b0;
      r_hold_idx <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hold_vld <= w_idle && w_fout_valid && !fout_ready_i;
      r_hold_idx <= w_win_idx;
      if (w_idle && w_xfer) begin
        r_rr_ptr  <= w_win_idx;
        r_lock_vc <= w_win_idx;
      end
      if (w_idle ? |(vc_valid_i & ~vc_head_i)
                 : (vc_valid_i[r_lock_vc] && vc_head_i[r_lock_vc])) begin
        r_err <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (USE_STARVE) begin
          if (w_xfer && w_gnt[i] && vc_head_i[i]) begin
            r_cnt[i] <= '0;
          end else if (w_elig[i] && !w_gnt[i] && (r_cnt[i] != CW'(STARVE_LIMIT))) begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign gnt_o        = arst ? '0 : w_gnt;
  assign gnt_vc_o     = arst ? '0 : w_gnt_idx;
  assign vc_ready_o   = arst ? '0 : (w_gnt & {N{fout_ready_i}});
  assign fout_valid_o = ~arst & w_fout_valid;
  assign locked_o     = ~arst & (r_state == SCH_LOCKED);
  assign err_o        = ~arst & r_err;

endmodule
